// File: rtl/score_pkg.sv
// score_pkg -- shared definitions for the score tracker.
//   evt_e       : event codes carried on evt_type
//   state_e     : score_tracker FSM states
//   ADD_*       : BCD point addends (score unit is 10 points)
//   stomp_points: STOMP chain table, used when SCORE_COMBO_EN is defined
//   bcd_inc2    : 2-digit packed BCD increment, wraps 99 -> 00
//   LIVES_INIT  : life count after reset
package score_pkg;

  typedef enum logic [2:0] {
    EVT_NOP   = 3'd0,
    EVT_COIN  = 3'd1,
    EVT_STOMP = 3'd2,
    EVT_BLOCK = 3'd3,
    EVT_FLAG  = 3'd4,
    EVT_LAND  = 3'd5,
    EVT_CLEAR = 3'd6,
    EVT_RSVD  = 3'd7
  } evt_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ADD  = 1'b1
  } state_e;

  localparam logic [15:0] ADD_COIN  = 16'h0020;
  localparam logic [15:0] ADD_BLOCK = 16'h0005;
  localparam logic [15:0] ADD_STOMP = 16'h0010;

  // Chain index saturates here; at this index STOMP scores nothing and awards a life.
  localparam logic [2:0] CHAIN_MAX = 3'd4;

  localparam logic [7:0] LIVES_INIT = 8'h03;

  function automatic logic [15:0] stomp_points(input logic [2:0] idx);
    case (idx)
      3'd0:    stomp_points = 16'h0010;
      3'd1:    stomp_points = 16'h0020;
      3'd2:    stomp_points = 16'h0040;
      3'd3:    stomp_points = 16'h0080;
      default: stomp_points = 16'h0000;
    endcase
  endfunction

  function automatic logic [7:0] bcd_inc2(input logic [7:0] v);
    logic [3:0] lo;
    logic [3:0] hi;
    lo = v[3:0];
    hi = v[7:4];
    if (lo == 4'd9) begin
      lo = 4'd0;
      hi = (hi == 4'd9) ? 4'd0 : hi + 4'd1;
    end else begin
      lo = lo + 4'd1;
    end
    bcd_inc2 = {hi, lo};
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// bcd_digit_add -- combinational single BCD digit adder.
//   a, b : input digits (0-9)
//   cin  : carry in
//   sum  : result digit (0-9)
//   cout : decimal carry out
module bcd_digit_add (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] raw;

  always_comb begin
    raw = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    // Binary results 10..19 are corrected by +6 to wrap into a legal digit.
    if (raw > 5'd9) begin
      sum  = raw[3:0] + 4'd6;
      cout = 1'b1;
    end else begin
      sum  = raw[3:0];
      cout = 1'b0;
    end
  end

endmodule

// File: rtl/score_tracker.sv
// score_tracker -- BCD score / coin / life tracker for game events.
//   Clk         : clock, rising edge
//   Reset       : synchronous active-high reset
//   evt_valid   : event offered; accepted when evt_valid && evt_ready
//   evt_ready   : high only in IDLE
//   evt_type    : event code (score_pkg::evt_e)
//   evt_arg     : FLAG height 0-7
//   Score       : 4-digit packed BCD score (unit 10 points), saturates at 9999
//   Coins       : 2-digit packed BCD coin count, wraps 99 -> 00 with a life award
//   Lives       : 2-digit packed BCD life count, saturates at 99
//   oneup_pulse : one-cycle strobe per life awarded
// Optional feature macro: SCORE_COMBO_EN (STOMP chain 10/20/40/80, then lives).
//
// Handshake: an event transfers on a rising edge where evt_valid and evt_ready
// are both high; evt_ready is a pure function of state, never of evt_valid.
// Non-zero addends run IDLE -> ADD (4 cycles, one digit per cycle, LSD first)
// -> IDLE; Score is committed in one write on the last ADD cycle.
module score_tracker
  import score_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic        evt_valid,
  output logic        evt_ready,
  input  logic [2:0]  evt_type,
  input  logic [2:0]  evt_arg,
  output logic [15:0] Score,
  output logic [7:0]  Coins,
  output logic [7:0]  Lives,
  output logic        oneup_pulse
);

  state_e      state;
  state_e      state_next;
  evt_e        evt;
  logic        accept;
  logic [15:0] addend;
  logic        award_life;
  logic [15:0] addend_q;
  logic [11:0] acc;
  logic [1:0]  digit_idx;
  logic        carry;
  logic [3:0]  dig_a;
  logic [3:0]  dig_b;
  logic [3:0]  dig_sum;
  logic        dig_cout;
`ifdef SCORE_COMBO_EN
  logic [2:0]  chain;
`endif

  assign evt    = evt_e'(evt_type);
  assign accept = evt_valid && evt_ready;

  // Event decode into an addend and a life award.
  always_comb begin
    addend     = 16'h0000;
    award_life = 1'b0;
    case (evt)
      EVT_COIN: begin
        addend     = ADD_COIN;
        award_life = (Coins == 8'h99);
      end
`ifdef SCORE_COMBO_EN
      EVT_STOMP: begin
        addend     = stomp_points(chain);
        award_life = (chain == CHAIN_MAX);
      end
`else
      EVT_STOMP: addend = ADD_STOMP;
`endif
      EVT_BLOCK: addend = ADD_BLOCK;
      EVT_FLAG:  addend = {5'b00000, evt_arg, 8'h00};
      default:   addend = 16'h0000;
    endcase
  end

  // FSM: state register
  always_ff @(posedge Clk) begin
    if (Reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // FSM: next state
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept && (addend != 16'h0000)) state_next = ST_ADD;
      ST_ADD:  if (digit_idx == 2'd3) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    evt_ready = (state == ST_IDLE);
  end

  // Digit datapath: the adder is shared by all four ADD cycles.
  assign dig_a = Score[{digit_idx, 2'b00} +: 4];
  assign dig_b = addend_q[{digit_idx, 2'b00} +: 4];

  bcd_digit_add u_digit_add (
    .a    (dig_a),
    .b    (dig_b),
    .cin  (carry),
    .sum  (dig_sum),
    .cout (dig_cout)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      Score       <= 16'h0000;
      Coins       <= 8'h00;
      Lives       <= LIVES_INIT;
      oneup_pulse <= 1'b0;
      addend_q    <= 16'h0000;
      acc         <= 12'h000;
      digit_idx   <= 2'd0;
      carry       <= 1'b0;
`ifdef SCORE_COMBO_EN
      chain       <= 3'd0;
`endif
    end else begin
      oneup_pulse <= 1'b0;
      if (accept) begin
        // Latching the decoded addend freezes evt_type/evt_arg for the ADD phase.
        addend_q  <= addend;
        digit_idx <= 2'd0;
        carry     <= 1'b0;
        if (award_life) begin
          oneup_pulse <= 1'b1;
          if (Lives != 8'h99) Lives <= bcd_inc2(Lives);
        end
        case (evt)
          EVT_COIN:  Coins <= bcd_inc2(Coins);
          EVT_CLEAR: begin
            Score <= 16'h0000;
            Coins <= 8'h00;
          end
          default: ;
        endcase
`ifdef SCORE_COMBO_EN
        case (evt)
          EVT_STOMP: if (chain != CHAIN_MAX) chain <= chain + 3'd1;
          EVT_LAND, EVT_CLEAR: chain <= 3'd0;
          default: ;
        endcase
`endif
      end else if (state == ST_ADD) begin
        carry     <= dig_cout;
        digit_idx <= digit_idx + 2'd1;
        case (digit_idx)
          2'd0: acc[3:0]  <= dig_sum;
          2'd1: acc[7:4]  <= dig_sum;
          2'd2: acc[11:8] <= dig_sum;
          // Carry out of the top digit means the sum passed 9999.
          default: Score <= dig_cout ? 16'h9999 : {dig_sum, acc};
        endcase
      end
    end
  end

endmodule

// File: tb/tb_score_tracker.sv
// tb_score_tracker -- directed bench for score_tracker.
// Table of single events with expected Score/Coins/Lives/latency, followed by
// hand-written sequences: coin rollover, score saturation, input changes
// during ADD, reset mid-ADD, reset priority, and STOMP chaining
// (SCORE_COMBO_EN selects the chain expectations).
module tb_score_tracker;
  import score_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        evt_valid;
  logic        evt_ready;
  logic [2:0]  evt_type;
  logic [2:0]  evt_arg;
  logic [15:0] Score;
  logic [7:0]  Coins;
  logic [7:0]  Lives;
  logic        oneup_pulse;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [2:0]  typ;
    logic [2:0]  arg;
    logic [15:0] score;
    logic [7:0]  coins;
    logic [7:0]  lives;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  // clock / reset block
  always #5 Clk = ~Clk;

  score_tracker dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .evt_type    (evt_type),
    .evt_arg     (evt_arg),
    .Score       (Score),
    .Coins       (Coins),
    .Lives       (Lives),
    .oneup_pulse (oneup_pulse)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_ready(output int cycles);
    cycles = 0;
    while (evt_ready !== 1'b1 && cycles < 20) begin
      tick();
      cycles++;
    end
    if (evt_ready !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_ready: evt_ready still low after %0d cycles", cycles);
    end
  endtask

  // Offers one event; returns #1 after the accepting edge.
  task automatic send(input logic [2:0] t, input logic [2:0] a);
    int c;
    wait_ready(c);
    evt_valid = 1'b1;
    evt_type  = t;
    evt_arg   = a;
    tick();
    evt_valid = 1'b0;
    evt_type  = EVT_NOP;
    evt_arg   = 3'd0;
  endtask

  task automatic do_evt(input logic [2:0] t, input logic [2:0] a, output int lat);
    send(t, a);
    wait_ready(lat);
  endtask

  initial begin
    int lat;

    vecs[0]  = '{EVT_COIN,  3'd0, 16'h0020, 8'h01, 8'h03, 4};
    vecs[1]  = '{EVT_BLOCK, 3'd0, 16'h0025, 8'h01, 8'h03, 4};
    vecs[2]  = '{EVT_FLAG,  3'd3, 16'h0325, 8'h01, 8'h03, 4};
    vecs[3]  = '{EVT_FLAG,  3'd0, 16'h0325, 8'h01, 8'h03, 0};
    vecs[4]  = '{EVT_NOP,   3'd5, 16'h0325, 8'h01, 8'h03, 0};
    vecs[5]  = '{EVT_RSVD,  3'd2, 16'h0325, 8'h01, 8'h03, 0};
    vecs[6]  = '{EVT_COIN,  3'd0, 16'h0345, 8'h02, 8'h03, 4};
    vecs[7]  = '{EVT_BLOCK, 3'd0, 16'h0350, 8'h02, 8'h03, 4};
    vecs[8]  = '{EVT_FLAG,  3'd7, 16'h1050, 8'h02, 8'h03, 4};
    vecs[9]  = '{EVT_CLEAR, 3'd0, 16'h0000, 8'h00, 8'h03, 0};
    vecs[10] = '{EVT_LAND,  3'd0, 16'h0000, 8'h00, 8'h03, 0};
    vecs[11] = '{EVT_STOMP, 3'd0, 16'h0010, 8'h00, 8'h03, 4};
    vecs[12] = '{EVT_BLOCK, 3'd0, 16'h0015, 8'h00, 8'h03, 4};
    vecs[13] = '{EVT_FLAG,  3'd5, 16'h0515, 8'h00, 8'h03, 4};

    Reset     = 1'b1;
    evt_valid = 1'b0;
    evt_type  = EVT_NOP;
    evt_arg   = 3'd0;
    repeat (2) tick();
    Reset = 1'b0;

    // reset state
    check("rst score", Score, 16'h0000);
    check("rst coins", {8'h00, Coins}, 16'h0000);
    check("rst lives", {8'h00, Lives}, 16'h0003);
    check("rst oneup", {15'd0, oneup_pulse}, 16'h0000);
    check("rst ready", {15'd0, evt_ready}, 16'h0001);

    // table of single events
    for (int i = 0; i < 14; i++) begin
      do_evt(vecs[i].typ, vecs[i].arg, lat);
      check($sformatf("v%0d score", i), Score, vecs[i].score);
      check($sformatf("v%0d coins", i), {8'h00, Coins}, {8'h00, vecs[i].coins});
      check($sformatf("v%0d lives", i), {8'h00, Lives}, {8'h00, vecs[i].lives});
      check($sformatf("v%0d latency", i), 16'(lat), 16'(vecs[i].lat));
    end

    // coin rollover: 0515 + 99*20 = 2495
    for (int i = 0; i < 99; i++) do_evt(EVT_COIN, 3'd0, lat);
    check("coins99 score", Score, 16'h2495);
    check("coins99 coins", {8'h00, Coins}, 16'h0099);
    send(EVT_COIN, 3'd0);
    check("roll oneup", {15'd0, oneup_pulse}, 16'h0001);
    check("roll coins", {8'h00, Coins}, 16'h0000);
    check("roll lives", {8'h00, Lives}, 16'h0004);
    tick();
    check("roll oneup off", {15'd0, oneup_pulse}, 16'h0000);
    wait_ready(lat);
    check("roll score", Score, 16'h2515);

    // saturation: 0020 + 14*700 + 100 + 14*5 = 9990
    do_evt(EVT_CLEAR, 3'd0, lat);
    do_evt(EVT_COIN, 3'd0, lat);
    for (int i = 0; i < 14; i++) do_evt(EVT_FLAG, 3'd7, lat);
    do_evt(EVT_FLAG, 3'd1, lat);
    for (int i = 0; i < 14; i++) do_evt(EVT_BLOCK, 3'd0, lat);
    check("sat pre", Score, 16'h9990);
    do_evt(EVT_BLOCK, 3'd0, lat);
    check("sat block1", Score, 16'h9995);
    do_evt(EVT_BLOCK, 3'd0, lat);
    check("sat block2", Score, 16'h9999);
    do_evt(EVT_BLOCK, 3'd0, lat);
    check("sat block3", Score, 16'h9999);
    check("sat coins", {8'h00, Coins}, 16'h0001);
    check("sat lives", {8'h00, Lives}, 16'h0004);

    // FLAG 7 with evt_valid held and evt_type changed during ADD
    do_evt(EVT_CLEAR, 3'd0, lat);
    evt_valid = 1'b1;
    evt_type  = EVT_FLAG;
    evt_arg   = 3'd7;
    tick();
    evt_type = EVT_COIN;
    evt_arg  = 3'd1;
    tick();
    check("hold ready low", {15'd0, evt_ready}, 16'h0000);
    lat = 0;
    while (evt_ready !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    evt_valid = 1'b0;
    evt_type  = EVT_NOP;
    evt_arg   = 3'd0;
    check("hold score", Score, 16'h0700);
    check("hold coins", {8'h00, Coins}, 16'h0000);
    repeat (2) tick();
    check("hold score after", Score, 16'h0700);
    check("hold coins after", {8'h00, Coins}, 16'h0000);
    check("hold ready after", {15'd0, evt_ready}, 16'h0001);

    // reset on the second ADD cycle of a COIN
    send(EVT_COIN, 3'd0);
    tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("midadd score", Score, 16'h0000);
    check("midadd coins", {8'h00, Coins}, 16'h0000);
    check("midadd lives", {8'h00, Lives}, 16'h0003);
    check("midadd ready", {15'd0, evt_ready}, 16'h0001);

    // reset wins over a simultaneous event
    evt_valid = 1'b1;
    evt_type  = EVT_COIN;
    Reset     = 1'b1;
    tick();
    Reset     = 1'b0;
    evt_valid = 1'b0;
    evt_type  = EVT_NOP;
    check("prio coins", {8'h00, Coins}, 16'h0000);
    check("prio ready", {15'd0, evt_ready}, 16'h0001);
    repeat (2) tick();
    check("prio score", Score, 16'h0000);

    // STOMP chain
`ifdef SCORE_COMBO_EN
    do_evt(EVT_STOMP, 3'd0, lat);
    check("chain1", Score, 16'h0010);
    do_evt(EVT_STOMP, 3'd0, lat);
    check("chain2", Score, 16'h0030);
    do_evt(EVT_STOMP, 3'd0, lat);
    check("chain3", Score, 16'h0070);
    do_evt(EVT_STOMP, 3'd0, lat);
    check("chain4", Score, 16'h0150);
    send(EVT_STOMP, 3'd0);
    check("chain5 oneup", {15'd0, oneup_pulse}, 16'h0001);
    check("chain5 lives", {8'h00, Lives}, 16'h0004);
    wait_ready(lat);
    check("chain5 latency", 16'(lat), 16'd0);
    check("chain5 score", Score, 16'h0150);
    do_evt(EVT_LAND, 3'd0, lat);
    do_evt(EVT_STOMP, 3'd0, lat);
    check("chain restart", Score, 16'h0160);
`else
    do_evt(EVT_STOMP, 3'd0, lat);
    check("stomp1", Score, 16'h0010);
    send(EVT_STOMP, 3'd0);
    check("stomp2 oneup", {15'd0, oneup_pulse}, 16'h0000);
    wait_ready(lat);
    check("stomp2", Score, 16'h0020);
    do_evt(EVT_LAND, 3'd0, lat);
    check("land latency", 16'(lat), 16'd0);
    do_evt(EVT_STOMP, 3'd0, lat);
    check("stomp3", Score, 16'h0030);
    check("stomp lives", {8'h00, Lives}, 16'h0003);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/score_tracker.md
SCORE_TRACKER -- requirements
Module: score_tracker

Interface
REQ-001 SHALL have port Clk, input, 1, system clock; all state changes on its rising edge.
REQ-002 SHALL have port Reset, input, 1, synchronous, active-high reset.
REQ-003 SHALL have port evt_valid, input, 1, game event offered this cycle.
REQ-004 SHALL have port evt_ready, output, 1, block accepts an event this cycle.
REQ-005 SHALL have port evt_type, input, 3, event code from score_pkg.
REQ-006 SHALL have port evt_arg, input, 3, FLAG height argument (0-7); ignored for other types.
REQ-007 SHALL have port Score, output, 16, 4-digit packed BCD score; unit is 10 points.
REQ-008 SHALL have port Coins, output, 8, 2-digit packed BCD coin count 00-99.
REQ-009 SHALL have port Lives, output, 8, 2-digit packed BCD life count.
REQ-010 SHALL have port oneup_pulse, output, 1, one-cycle strobe per life awarded.

Function
REQ-011 SHALL accept an event only on a cycle where evt_valid and evt_ready are both high.
REQ-012 SHALL drive evt_ready high only in state IDLE.
REQ-013 SHALL decode event codes: 0 NOP; 1 COIN (+20, Coins+1); 2 STOMP (chain value); 3 BLOCK (+5); 4 FLAG (+arg x 100, BCD 0x0{arg}00); 5 LAND (reset chain, no points); 6 CLEAR (Score and Coins to 0, chain reset); 7 reserved, treated as NOP.
REQ-014 SHALL use the FSM IDLE -> ADD -> IDLE, where ADD processes one BCD digit per cycle, least significant first, over 4 cycles.
REQ-015 SHALL treat NOP, LAND, CLEAR, reserved events, and zero-addend events as single-cycle events: IDLE -> IDLE, with the effect visible the cycle after acceptance.
REQ-016 SHALL make an updated Score visible on the cycle after the 4th ADD cycle, with evt_ready high again on that same cycle (5 cycles from acceptance to next acceptance).
REQ-017 SHALL keep Score unchanged during ADD until the final digit is written, with all four digits updated together.
REQ-018 SHALL saturate Score at 0x9999 on carry out of digit 3; no wrap.
REQ-019 SHALL increment Coins by BCD +1 the cycle after COIN acceptance.
REQ-020 SHALL, on COIN at Coins=0x99, wrap Coins to 0x00, award one life, and pulse oneup_pulse.
REQ-021 SHALL saturate Lives at 0x99; oneup_pulse SHALL still fire when Lives is saturated.
REQ-022 SHALL latch evt_type and evt_arg at acceptance; input changes during ADD SHALL have no effect.
REQ-023 SHALL keep every digit of Score, Coins, and Lives a legal BCD digit (0-9) at all times.

Reset
REQ-024 SHALL, on Reset high at a clock edge, force: Score 0x0000, Coins 0x00, Lives 0x03, oneup_pulse 0, chain index 0, FSM IDLE, evt_ready 1 on the following cycle.
REQ-025 SHALL, on Reset asserted mid-ADD, abandon the addition without a partial Score update.
REQ-026 SHALL give Reset priority over any simultaneous event.

Configuration
REQ-027 SHALL support macro SCORE_COMBO_EN.
- Defined: consecutive STOMPs without an intervening LAND or CLEAR add 10, 20, 40, 80; the 5th and later consecutive STOMPs add no points and award a life each.
- Not defined: every STOMP adds 10, no chain state exists, and LAND is a NOP.

Structure
REQ-028 SHALL place in shared package score_pkg:
- the event-code enum;
- point addend constants (COIN 0x0020, BLOCK 0x0005, STOMP chain table);
- LIVES_INIT 0x03.
REQ-029 SHALL instantiate one sub-module, bcd_digit_add: 4-bit digit + 4-bit digit + carry-in -> digit + carry-out, combinational, reused each ADD cycle.

Verification
REQ-030 SHALL verify: reset, then COIN -> 5 cycles later Score=0x0020, Coins=0x01, evt_ready high.
REQ-031 SHALL verify: preload Coins=0x99 via 99 COINs, then one COIN -> Coins=0x00, Lives=0x04, oneup_pulse high exactly 1 cycle.
REQ-032 SHALL verify: Score=0x9990 and BLOCK x3 -> Score=0x9999 (saturated), Coins unchanged.
REQ-033 SHALL verify: with SCORE_COMBO_EN, STOMP x5 -> Score +0x0150, Lives 0x04; then LAND, STOMP -> +0x0010.
REQ-034 SHALL verify: FLAG arg=7 with evt_valid held and evt_type changed during ADD -> Score +0x0700, only one event consumed.
REQ-035 SHALL verify: Reset on 2nd ADD cycle of COIN -> Score 0x0000, Coins 0x00, Lives 0x03, evt_ready high the next cycle.
